omsp_hash_control_gen: RTL and testbench

Parametrised second-generation hash sequencer for the Sancus SPM crypto path. It reads the SPM layout words (public start/end plus optional secret bounds) from the SPM file and streams the public section and those layout words into an external hash engine. It then either verifies the engine digest against a digest in memory (MODE_VERIFY) or writes the digest to memory (MODE_STORE). It sits between the SPM register file, the memory backbone and a hash core (SHA-512 or a narrower digest), and reports the result by writing the SPM ID, or zero on failure, to the register file.

---
 rtl/omsp_hash_pkg.sv | 28 ++
 rtl/omsp_hash_wait_cnt.sv | 26 ++
 rtl/omsp_hash_control_gen.sv | 190 +++++++++++++++++++
 tb/tb_omsp_hash_control_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_hash_pkg.sv
// Shared types and helpers for the SPM hash sequencer.
package omsp_hash_pkg;

    localparam logic MODE_VERIFY = 1'b0;
    localparam logic MODE_STORE  = 1'b1;

    localparam logic [1:0] HCMD_IDLE = 2'b00;
    localparam logic [1:0] HCMD_PUSH = 2'b10;
    localparam logic [1:0] HCMD_READ = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ_META,
        ST_RANGE_CHK,
        ST_FEED_MEM,
        ST_FEED_META,
        ST_FLUSH,
        ST_RD_START,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_DONE
    } hash_state_t;

    function automatic logic [15:0] bswap(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/omsp_hash_wait_cnt.sv
// Loadable down-counter with zero flag; paces the digest-read wait and word index.
module omsp_hash_wait_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/omsp_hash_control_gen.sv
// SPM hash sequencer: streams the public section plus layout words into a hash
// engine, then verifies or stores the resulting digest.
module omsp_hash_control_gen
    import omsp_hash_pkg::*;
#(
    parameter int HASH_WORDS   = 32,
    parameter int META_WORDS   = 4,
    parameter int READ_LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] hash_address,
    input  logic [15:0] spm_data,
    input  logic [15:0] mem_data,
    output logic [2:0]  spm_request,
    output logic [15:0] mab,
    output logic        mb_en,
    output logic [1:0]  mb_wr,
    output logic [15:0] mb_dout,
    output logic [1:0]  hash_cmd,
    output logic [15:0] hash_data,
    input  logic        hash_ready,
    input  logic        hash_busy,
    input  logic [15:0] hash_word,
    output logic [15:0] data_out,
    output logic        reg_write,
    output logic        fail,
    output logic        busy
);

    // SPM file field codes
    localparam logic [2:0] SPM_REQ_PUBSTART = 3'd0;
    localparam logic [2:0] SPM_REQ_ID       = 3'd4;

    localparam logic [1:0] K_LAST  = 2'(META_WORDS - 1);
    localparam logic [4:0] HW_LAST = 5'(HASH_WORDS - 1);
    localparam logic [4:0] WAIT_LD = 5'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

    hash_state_t state, state_n;
    logic [15:0] meta [0:3];
    logic [1:0]  k;
    logic        mode_q, rd_vld;
    logic        cnt_load, cnt_dec, cnt_zero, pre_data, miss;
    logic [4:0]  cnt_val;
    logic [15:0] pe_w, ps_w;

    assign ps_w     = meta[0] & 16'hFFFE;
    assign pe_w     = meta[1] & 16'hFFFE;
    assign busy     = (state != ST_IDLE) || start;
    assign data_out = fail ? 16'h0 : spm_data;

    omsp_hash_wait_cnt #(.W(5)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        spm_request = SPM_REQ_ID;
        mb_en       = 1'b0;
        mb_wr       = 2'b00;
        mb_dout     = 16'h0;
        hash_cmd    = HCMD_IDLE;
        hash_data   = 16'h0;
        reg_write   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = HW_LAST;
        pre_data    = 1'b0;
        miss        = 1'b0;
        case (state)
            ST_IDLE:      if (start) state_n = ST_READ_META;
            ST_READ_META: begin
                spm_request = SPM_REQ_PUBSTART + {1'b0, k};
                if (k == K_LAST) state_n = ST_RANGE_CHK;
            end
            ST_RANGE_CHK: state_n = (meta[1] < meta[0]) ? ST_DONE : ST_FEED_MEM;
            ST_FEED_MEM: begin
                // read and push alternate; a refused push re-reads the same word
                mb_en = 1'b1;
                if (rd_vld) begin
                    hash_cmd  = HCMD_PUSH;
                    hash_data = bswap(mem_data);
                    if (hash_ready && mab == pe_w) state_n = ST_FEED_META;
                end
            end
            ST_FEED_META: begin
                hash_cmd  = HCMD_PUSH;
                hash_data = meta[k];
                if (hash_ready && k == K_LAST) state_n = ST_FLUSH;
            end
            ST_FLUSH:     if (!hash_busy) state_n = ST_RD_START;
            ST_RD_START: begin
                hash_cmd = HCMD_READ;
                cnt_load = 1'b1;
                if (READ_LATENCY == 1) begin
                    state_n  = ST_RD_DATA;
                    pre_data = 1'b1;
                end else begin
                    state_n = ST_RD_WAIT;
                    cnt_val = WAIT_LD;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    state_n  = ST_RD_DATA;
                    cnt_load = 1'b1;
                    pre_data = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_DATA: begin
                mb_en   = 1'b1;
                cnt_dec = 1'b1;
                if (mode_q == MODE_STORE) begin
                    mb_wr   = 2'b11;
                    mb_dout = bswap(hash_word);
                end else begin
                    miss = (mem_data != bswap(hash_word));
                end
                if (miss || cnt_zero) state_n = ST_DONE;
            end
            ST_DONE: begin
                reg_write = 1'b1;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        // verify reads run one cycle ahead so mem_data lines up with hash_word
        if (pre_data && mode_q == MODE_VERIFY) mb_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mab    <= 16'h0;
            k      <= 2'd0;
            mode_q <= MODE_VERIFY;
            fail   <= 1'b0;
            rd_vld <= 1'b0;
            for (int j = 0; j < 4; j++) meta[j] <= 16'h0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    mode_q <= mode;
                    fail   <= 1'b0;
                    k      <= 2'd0;
                end
                ST_READ_META: begin
                    meta[k] <= spm_data;
                    k       <= (k == K_LAST) ? 2'd0 : k + 2'd1;
                end
                ST_RANGE_CHK: begin
                    if (meta[1] < meta[0]) fail <= 1'b1;
                    mab    <= ps_w;
                    rd_vld <= 1'b0;
                end
                ST_FEED_MEM: begin
                    if (!rd_vld) begin
                        rd_vld <= 1'b1;
                    end else if (hash_ready) begin
                        rd_vld <= 1'b0;
                        mab    <= mab + 16'd2;
                    end
                end
                ST_FEED_META: if (hash_ready) k <= (k == K_LAST) ? 2'd0 : k + 2'd1;
                ST_FLUSH:     mab <= hash_address & 16'hFFFE;
                ST_RD_START, ST_RD_WAIT:
                    if (pre_data && mode_q == MODE_VERIFY) mab <= mab + 16'd2;
                ST_RD_DATA: begin
                    mab <= mab + 16'd2;
                    if (miss) fail <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_omsp_hash_control_gen.sv
// Directed and randomized checks of the SPM hash sequencer against a stream/digest model.
module tb_omsp_hash_control_gen;

    localparam int HW = 4;
    localparam int MW = 4;
    localparam int RL = 5;
    localparam logic [15:0] FIX [0:3] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, mode = 1'b0;
    logic [15:0] hash_address = 16'h0;
    logic [15:0] spm_data, mab, mb_dout, hash_data, data_out;
    logic [15:0] mem_data = 16'h0BAD, hash_word = 16'h0BAD;
    logic        hash_ready = 1'b1, hash_busy = 1'b0;
    logic [2:0]  spm_request;
    logic [1:0]  mb_wr, hash_cmd;
    logic        mb_en, reg_write, fail, busy;

    logic [15:0] spm_tab [0:7];
    logic [15:0] mem [0:32767];

    always #5 clk = ~clk;
    assign spm_data = spm_tab[spm_request];

    omsp_hash_control_gen #(.HASH_WORDS(HW), .META_WORDS(MW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hash_address(hash_address),
        .spm_data(spm_data), .mem_data(mem_data), .spm_request(spm_request), .mab(mab),
        .mb_en(mb_en), .mb_wr(mb_wr), .mb_dout(mb_dout), .hash_cmd(hash_cmd),
        .hash_data(hash_data), .hash_ready(hash_ready), .hash_busy(hash_busy),
        .hash_word(hash_word), .data_out(data_out), .reg_write(reg_write),
        .fail(fail), .busy(busy)
    );

    function automatic logic [15:0] swp(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    // engine digest: order-sensitive fold of everything pushed
    function automatic logic [15:0] dig_of(input logic [15:0] q[$], input int i);
        logic [15:0] h;
        h = 16'h5A5A;
        foreach (q[j]) h = {h[14:0], h[15]} ^ q[j];
        return h + 16'(i) * 16'h1357;
    endfunction

    // memory + hash engine environment
    int          cyc = 0, rd_cyc = -1, rw_cnt = 0, rw_cyc = 0, push_tot = 0;
    int          seen_tot = 0, busy_cnt = 0, m_off = 0;
    logic        clr = 1'b0, fixed_dig = 1'b0, rd_pend = 1'b0, rw_fail = 1'b0;
    logic [15:0] rd_addr = 16'h0, rw_data = 16'h0;
    logic [15:0] pushq[$], wr_a[$], wr_d[$];
    logic [15:0] eng_dig [0:HW-1];

    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            pushq.delete(); wr_a.delete(); wr_d.delete();
            rd_cyc = -1;
            rw_cnt = 0;
        end else begin
            if (hash_cmd == 2'b10 && hash_ready) begin
                pushq.push_back(hash_data);
                push_tot++;
            end
            if (hash_cmd == 2'b01) begin
                rd_cyc = cyc;
                for (int i = 0; i < HW; i++) eng_dig[i] = fixed_dig ? FIX[i] : dig_of(pushq, i);
            end
            if (mb_en && mb_wr == 2'b11) begin
                wr_a.push_back(mab);
                wr_d.push_back(mb_dout);
            end
            if (reg_write) begin
                rw_cnt++;
                rw_data = data_out;
                rw_fail = fail;
                rw_cyc  = cyc;
            end
        end
        rd_pend = mb_en && (mb_wr == 2'b00);
        rd_addr = mab;
    end

    always @(posedge clk) begin
        #1;
        mem_data  = rd_pend ? mem[rd_addr[15:1]] : 16'h0BAD;
        m_off     = cyc + 1 - rd_cyc;
        hash_word = (rd_cyc >= 0 && m_off >= RL && m_off < RL + HW) ? eng_dig[m_off - RL] : 16'h0BAD;
        if (push_tot != seen_tot) begin
            seen_tot = push_tot;
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        hash_busy = (busy_cnt != 0);
    end

    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_dig [0:HW-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_env();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic md, input logic [15:0] ha,
                          input logic [15:0] ps, input logic [15:0] pe,
                          input logic fixed, input logic stall, input int corrupt);
        bit range_bad, exp_fail;
        int exp_lat, bad, to;
        spm_tab[0] = ps; spm_tab[1] = pe;
        spm_tab[2] = 16'($urandom); spm_tab[3] = 16'($urandom); spm_tab[4] = 16'h0003;
        fixed_dig = fixed;
        clear_env();
        range_bad = (pe < ps);
        exp_q.delete();
        if (!range_bad) begin
            for (int a = int'(ps & 16'hFFFE); a <= int'(pe & 16'hFFFE); a += 2)
                exp_q.push_back(swp(mem[a / 2]));
            for (int j = 0; j < MW; j++) exp_q.push_back(spm_tab[j]);
        end
        for (int i = 0; i < HW; i++) exp_dig[i] = fixed ? FIX[i] : dig_of(exp_q, i);
        if (md == 1'b0)
            for (int i = 0; i < HW; i++)
                mem[ha[15:1] + 15'(i)] = swp(exp_dig[i]) ^ ((i == corrupt) ? 16'h0100 : 16'h0);
        exp_fail = range_bad || (md == 1'b0 && corrupt >= 0 && corrupt < HW);
        exp_lat  = RL + ((md == 1'b0 && corrupt >= 0 && corrupt < HW) ? corrupt + 1 : HW);

        mode = md; hash_address = ha; start = 1'b1; tick(); start = 1'b0;
        if (stall) begin
            to = 0;
            while (pushq.size() < 2 && to < 200) begin tick(); to++; end
            hash_ready = 1'b0;
            start = 1'b1; mode = ~md; tick(); start = 1'b0; mode = md;
            tick(); tick();
            hash_ready = 1'b1;
        end
        to = 0;
        while (rw_cnt == 0 && to < 1000) begin tick(); to++; end
        if (rw_cnt == 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
        repeat (4) tick();

        chk({nm, "_rw_cnt"}, rw_cnt, 1);
        chk({nm, "_data_out"}, rw_data, exp_fail ? 16'h0 : 16'h0003);
        chk({nm, "_fail_at_wr"}, rw_fail, exp_fail);
        chk({nm, "_fail"}, fail, exp_fail);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_push_cnt"}, pushq.size(), exp_q.size());
        bad = 0;
        foreach (exp_q[j]) if (j >= pushq.size() || pushq[j] !== exp_q[j]) bad++;
        chk({nm, "_stream"}, bad, 0);
        if (range_bad) chk({nm, "_no_read"}, rd_cyc, -1);
        else           chk({nm, "_latency"}, rw_cyc - rd_cyc, exp_lat);
        if (md == 1'b1) begin
            chk({nm, "_wr_cnt"}, wr_a.size(), HW);
            bad = 0;
            foreach (wr_a[i])
                if (i >= HW || wr_a[i] !== (ha & 16'hFFFE) + 16'(2 * i) || wr_d[i] !== swp(exp_dig[i])) bad++;
            chk({nm, "_writes"}, bad, 0);
        end else begin
            chk({nm, "_no_wr"}, wr_a.size(), 0);
        end
    endtask

    initial begin
        logic [15:0] ps, ha;
        int to;
        for (int i = 0; i < 8; i++) spm_tab[i] = 16'h0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

        repeat (3) tick();
        @(negedge clk);
        chk("rst_mb_en", mb_en, 0);
        chk("rst_mb_wr", mb_wr, 0);
        chk("rst_hash_cmd", hash_cmd, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_spm_req", spm_request, 4);
        chk("rst_mab", mab, 0);
        chk("rst_fail", fail, 0);
        chk("rst_busy", busy, 0);
        tick(); rst = 1'b0; tick();

        run_op("t1_verify", 1'b0, 16'h9000, 16'h8000, 16'h8006, 1'b0, 1'b0, -1);
        run_op("t2_corrupt", 1'b0, 16'h9000, 16'h8000, 16'h8006, 1'b0, 1'b0, 2);
        run_op("t3_store", 1'b1, 16'h9000, 16'h8000, 16'h8006, 1'b1, 1'b0, -1);
        chk("t3_w0_data", wr_d.size() > 0 ? wr_d[0] : 16'hFFFF, 16'h2211);
        chk("t3_w1_data", wr_d.size() > 1 ? wr_d[1] : 16'hFFFF, 16'h4433);
        run_op("t4_stall", 1'b0, 16'h9100, 16'h8101, 16'h8107, 1'b0, 1'b1, -1);
        run_op("t5_range", 1'b0, 16'h9000, 16'h8000, 16'h7FFE, 1'b0, 1'b0, -1);
        run_op("t5_single", 1'b0, 16'h9200, 16'h8010, 16'h8010, 1'b0, 1'b0, -1);
        for (int r = 0; r < 6; r++) begin
            ps = 16'h8000 + 16'($urandom_range(0, 255));
            ha = 16'hA000 + 16'($urandom_range(0, 127) * 16);
            run_op($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), ha, ps,
                   ps + 16'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)),
                   (r % 3 == 1) ? int'($urandom_range(0, HW - 1)) : -1);
        end

        // reset in the middle of the digest wait
        spm_tab[0] = 16'h8000; spm_tab[1] = 16'h8002;
        clear_env();
        mode = 1'b0; hash_address = 16'h9000; start = 1'b1; tick(); start = 1'b0;
        to = 0;
        while (rd_cyc < 0 && to < 300) begin tick(); to++; end
        chk("t6_reached_rd", rd_cyc >= 0, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_hash_cmd", hash_cmd, 0);
        chk("t6_mb_en", mb_en, 0);
        chk("t6_mab", mab, 0);
        chk("t6_spm_req", spm_request, 4);
        chk("t6_reg_write", reg_write, 0);
        repeat (20) tick();
        chk("t6_no_rw", rw_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
